// File: rtl/mips_run_ctrl.sv
// Run controller for a MIPS core: reset hold, free run to a halt PC, single-step, abort.
// Optional cycle-budget stop is enabled by defining RUN_CTRL_TIMEOUT_EN.
module mips_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             abort,
  input  logic [31:0]      halt_addr,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [31:0]      pc_current,
  output logic             cpu_rst,
  output logic             cpu_ce,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_STEP, S_STOP} state_e;

  localparam logic [3:0] HOLD_LAST = 4'(RST_CYCLES - 1);

  state_e           state_q;
  logic [3:0]       hold_q;
  logic             recheck_q;
  logic             done_q, hit_q, timeout_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_match, budget_hit;

  assign pc_match = (pc_current == halt_addr);

`ifdef RUN_CTRL_TIMEOUT_EN
  assign budget_hit = (max_cycles != '0) && (cnt_q == max_cycles);
`else
  logic unused_max;
  assign unused_max = ^max_cycles;
  assign budget_hit = 1'b0;
`endif

  // Only the enable is combinational so the core freezes on the very cycle PC hits halt_addr.
  always_comb begin
    cpu_ce = 1'b0;
    case (state_q)
      S_RUN:   cpu_ce = !abort && !pc_match && !budget_hit;
      S_STEP:  cpu_ce = !abort;
      default: cpu_ce = 1'b0;
    endcase
  end

  assign cnt_d = (cpu_ce && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  assign cpu_rst   = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign busy      = (state_q == S_HOLD) || (state_q == S_RUN) || (state_q == S_STEP);
  assign done      = done_q;
  assign hit       = hit_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      recheck_q <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      recheck_q <= 1'b0;
      case (state_q)
        S_IDLE, S_STOP: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (start) begin
            state_q   <= S_HOLD;
            hold_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            timeout_q <= 1'b0;
          end else if (state_q == S_STOP && step) begin
            state_q <= S_STEP;
          end else if (state_q == S_STOP && recheck_q) begin
            // PC only settles after the stepped edge, so the match is taken a cycle later.
            hit_q <= pc_match;
          end
        end
        S_HOLD: begin
          if (abort)                   state_q <= S_IDLE;
          else if (hold_q == HOLD_LAST) state_q <= S_RUN;
          else                          hold_q  <= hold_q + 4'd1;
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (pc_match) begin
            state_q   <= S_STOP;
            hit_q     <= 1'b1;
            done_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else if (budget_hit) begin
            state_q   <= S_STOP;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end
        end
        S_STEP: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else begin
            state_q   <= S_STOP;
            recheck_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: run table with a scoreboard, plus step/abort/reset sequences.
module tb_mips_run_ctrl;

  localparam int RSTC = 2;
`ifdef RUN_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, step, abort;
  logic [31:0] halt_addr, pc;
  logic [15:0] max_cycles, cycle_cnt;
  logic        cpu_rst, cpu_ce, busy, done, hit, timeout;

  mips_run_ctrl #(.RST_CYCLES(RSTC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .abort(abort),
    .halt_addr(halt_addr), .max_cycles(max_cycles), .pc_current(pc),
    .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .busy(busy), .done(done),
    .hit(hit), .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Processor model: PC advances by 4 on every enabled cycle, cleared while held in reset.
  always @(posedge clk or negedge rst)
    if (!rst)         pc <= '0;
    else if (cpu_rst) pc <= '0;
    else if (cpu_ce)  pc <= pc + 32'd4;

  typedef struct {
    logic [31:0] halt;
    logic [15:0] maxc;
    logic [15:0] cnt;
    logic [31:0] pc;
    logic        hit;
    logic        to;
  } vec_t;

  vec_t tbl[7];
  vec_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t model(input logic [31:0] h, input logic [15:0] m);
    vec_t v;
    int   steps;
    steps  = int'(h >> 2);
    v.halt = h;
    v.maxc = m;
    if (TO_EN && m != 0 && int'(m) < steps) begin
      v.cnt = m; v.pc = {14'd0, m, 2'b00}; v.hit = 1'b0; v.to = 1'b1;
    end else begin
      v.cnt = 16'(steps); v.pc = h; v.hit = 1'b1; v.to = 1'b0;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_one(input vec_t v);
    int   holds;
    bit   got;
    vec_t e;
    @(negedge clk);
    halt_addr = v.halt; max_cycles = v.maxc; start = 1'b1;
    sbq.push_back(v);
    holds = 0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk); start = 1'b0;
      if (busy && cpu_rst) holds++;
      if (done && !busy) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    e = sbq.pop_front();
    chk("hold_len", holds, RSTC);
    chk("run_cnt", 32'(cycle_cnt), 32'(e.cnt));
    chk("run_pc", pc, e.pc);
    chk("run_hit", 32'(hit), 32'(e.hit));
    chk("run_timeout", 32'(timeout), 32'(e.to));
    chk("stop_ce", 32'(cpu_ce), 32'd0);
    chk("stop_cpu_rst", 32'(cpu_rst), 32'd0);
    repeat (3) @(negedge clk);
    chk("pc_frozen", pc, e.pc);
  endtask

  task automatic start_run(input logic [31:0] h);
    @(negedge clk);
    halt_addr = h; max_cycles = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_cnt(input logic [15:0] n);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (cycle_cnt == n) got = 1'b1;
      else @(negedge clk);
    end
    chk("reach_cnt", 32'(got), 32'd1);
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done && !busy) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  task automatic do_step(input logic [31:0] h, output int ces);
    @(negedge clk);
    halt_addr = h; step = 1'b1;
    ces = 0;
    repeat (6) begin
      @(negedge clk); step = 1'b0;
      if (cpu_ce) ces++;
    end
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] cnt);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_ce"}, 32'(cpu_ce), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cnt"}, 32'(cycle_cnt), 32'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ces;
    tbl[0] = model(32'h58, 16'd0);
    tbl[1] = model(32'h58, 16'd13);
    tbl[2] = model(32'h00, 16'd0);
    tbl[3] = model(32'h10, 16'd4);
    tbl[4] = model(32'h40, 16'd20);
    tbl[5] = model(32'h100, 16'd5);
    tbl[6] = model(32'h20, 16'd9);

    rst = 1'b0; start = 1'b0; step = 1'b0; abort = 1'b0;
    halt_addr = '0; max_cycles = '0;
    repeat (3) @(negedge clk);
    chk_idle("rst_low", 16'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("rst_rel", 16'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // step while idle does nothing
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    chk_idle("step_idle", 16'd0);

    foreach (tbl[i]) run_one(tbl[i]);

    // single-step out of a halt-match stop
    run_one(tbl[0]);
    do_step(32'h5C, ces);
    chk("step1_ces", ces, 1);
    chk("step1_pc", pc, 32'h5C);
    chk("step1_cnt", 32'(cycle_cnt), 32'd23);
    chk("step1_hit", 32'(hit), 32'd1);
    chk("step1_done", 32'(done), 32'd1);
    chk("step1_busy", 32'(busy), 32'd0);
    do_step(32'h58, ces);
    chk("step2_ces", ces, 1);
    chk("step2_pc", pc, 32'h60);
    chk("step2_cnt", 32'(cycle_cnt), 32'd24);
    chk("step2_hit", 32'(hit), 32'd0);

    // start and step together in STOP: start wins
    @(negedge clk); halt_addr = 32'h58; start = 1'b1; step = 1'b1;
    @(negedge clk); start = 1'b0; step = 1'b0;
    chk("start_beats_step", 32'(busy && cpu_rst), 32'd1);
    wait_done();
    chk("rerun_cnt", 32'(cycle_cnt), 32'd22);

    // start during RUN is ignored
    start_run(32'h58);
    wait_cnt(16'd3);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_in_run_rst", 32'(cpu_rst), 32'd0);
    chk("start_in_run_cnt", 32'(cycle_cnt), 32'd4);
    wait_done();
    chk("start_in_run_final", 32'(cycle_cnt), 32'd22);

    // abort together with start at cycle_cnt 5
    start_run(32'h58);
    wait_cnt(16'd5);
    abort = 1'b1; start = 1'b1;
    #1 chk("abort_ce", 32'(cpu_ce), 32'd0);
    @(negedge clk); abort = 1'b0; start = 1'b0;
    chk_idle("abort", 16'd5);
    repeat (3) @(negedge clk);
    chk_idle("abort_hold", 16'd5);
    chk("abort_done", 32'(done), 32'd0);

    // reset mid-run, then rerun the baseline
    start_run(32'h58);
    wait_cnt(16'd7);
    rst = 1'b0;
    #1 chk_idle("midrst", 16'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hit", 32'(hit), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("midrst_rel", 16'd0);
    run_one(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2: CPU reset-hold length in cycles (1..15).
REQ-002 SHALL have parameter CNT_W, default 16: width of cycle counter and budget.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begin a run.
REQ-006 SHALL have port step  input  1  one-cycle pulse; execute one instruction while stopped.
REQ-007 SHALL have port abort  input  1  one-cycle pulse; return to idle.
REQ-008 SHALL have port halt_addr  input  32  PC value at which the run stops.
REQ-009 SHALL have port max_cycles  input  CNT_W  cycle budget; 0 = unlimited.
REQ-010 SHALL have port pc_current  input  32  processor PC.
REQ-011 SHALL have port cpu_rst  output  1  active-high reset to the processor.
REQ-012 SHALL have port cpu_ce  output  1  processor clock enable.
REQ-013 SHALL have ports busy, done, hit, timeout  output  1 each  status flags.
REQ-014 SHALL have port cycle_cnt  output  CNT_W  enabled cycles in current run.

Function
REQ-015 SHALL implement states IDLE, HOLD, RUN, STEP, STOP.
REQ-016 IDLE: cpu_rst=1, cpu_ce=0, busy=0; start -> HOLD, clearing cycle_cnt, done, hit, timeout.
REQ-017 HOLD: cpu_rst=1, cpu_ce=0, busy=1 for exactly RST_CYCLES cycles, then -> RUN.
REQ-018 RUN: cpu_rst=0, busy=1; cpu_ce combinational = (pc_current != halt_addr), so the PC freezes at halt_addr.
REQ-019 RUN: each cycle with cpu_ce=1 SHALL increment cycle_cnt, saturating at all-ones.
REQ-020 RUN: pc_current == halt_addr -> STOP with hit=1, done=1 next edge.
REQ-021 STOP: cpu_rst=0, cpu_ce=0, busy=0, done=1; processor state held for inspection.
REQ-022 STOP: step -> STEP; STEP asserts cpu_ce=1 for exactly one cycle, increments cycle_cnt, returns to STOP; hit recomputed on return.
REQ-023 start in STOP -> HOLD (new run); start in HOLD, RUN or STEP SHALL be ignored.
REQ-024 step outside STOP SHALL be ignored.
REQ-025 abort in any state -> IDLE next edge, cpu_ce=0 that cycle; flags and cycle_cnt retained.
REQ-026 Simultaneous pulses: abort beats start beats step.
REQ-027 halt match beats budget expiry in the same cycle (hit=1, timeout=0).
REQ-028 All outputs except cpu_ce SHALL be registered or decoded from state only.

Reset
REQ-029 rst low SHALL immediately force IDLE, cpu_rst=1, cpu_ce=0, busy=0, done=0, hit=0, timeout=0, cycle_cnt=0.
REQ-030 rst asserted mid-run SHALL discard the run; no further action until a new start after rst deasserts.

Configuration
REQ-031 Macro RUN_CTRL_TIMEOUT_EN defined: in RUN, cycle_cnt == max_cycles (max_cycles != 0) -> STOP with timeout=1, done=1, cpu_ce=0 that cycle.
REQ-032 Macro RUN_CTRL_TIMEOUT_EN undefined: max_cycles ignored, timeout tied 0, run ends only on halt match or abort.

Verification
REQ-033 rst low then high, no stimulus -> cpu_rst=1, cpu_ce=0, all flags 0, cycle_cnt=0.
REQ-034 start, halt_addr=0x58, PC model +4 per enabled cycle from 0 -> cpu_rst high 2 cycles, cycle_cnt=22, hit=1, done=1, PC stays 0x58.
REQ-035 After REQ-034, halt_addr=0x5C, step -> exactly one cpu_ce cycle, PC=0x5C, cycle_cnt=23, hit=1.
REQ-036 TIMEOUT_EN, max_cycles=13, halt_addr=0x58 -> STOP at cycle_cnt=13, timeout=1, hit=0, PC=0x34.
REQ-037 abort at cycle_cnt=5 together with start -> IDLE, cpu_rst=1, start ignored, cycle_cnt=5.
REQ-038 rst low during RUN -> immediate IDLE, all flags 0; start after release reruns REQ-034 identically.
